// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared core types.
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t - unified-port arbiter state (IDLE, IGRANT, DGRANT); also
//                 visible to the hazard unit and testbenches
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: groups the cache-side and RAM-side signals of the
// unified memory port arbiter.
//   Fetch side : halt, iREN, iaddr -> ihit, iload
//   Data side  : dREN, dWEN, daddr, dstore -> dhit, dload
//   RAM side   : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate
//   Status     : bus_err (sticky timeout flag)
// Modports: slave = arbiter view, master = datapath/RAM (environment) view.
interface mem_port_arbiter_if;
  import cpu_types_pkg::*;

  logic      halt;
  logic      iREN;
  word_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      bus_err;

  modport slave (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport master (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single RAM port between instruction fetch and
// data access. Data has priority; after DSTREAK_MAX consecutive data grants
// with a fetch waiting, the fetch is forced. Each grant times out after
// TIMEOUT cycles without ACCESS (sticky bus_err, hit with zero data).
// halt blocks new fetch grants only.
// Ports:
//   CLK  - clock, rising edge
//   nRST - synchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (cache-side and RAM-side signals)
module mem_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic                 CLK,
  input logic                 nRST,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t state_q, state_d;
  logic [7:0] waitcnt_q, waitcnt_d;
  logic [2:0] dstreak_q, dstreak_d;
  logic       bus_err_q;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       wen_q, wen_d;

  logic  d_req, fetch_ok, force_fetch, access, expired;
  logic  ihit, dhit, timeout;
  logic  ram_ren, ram_wen;
  word_t ram_addr, ram_store, iload, dload;

  assign d_req    = bus.dREN | bus.dWEN;
  assign fetch_ok = bus.iREN & ~bus.halt;
  // >= rather than ==: the streak may saturate past the limit while halt
  // holds fetch off, and the fetch must still be forced once halt clears.
  assign force_fetch = fetch_ok && (dstreak_q >= 3'(DSTREAK_MAX));
  assign access  = (bus.ramstate == ACCESS);
  assign expired = (waitcnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !force_fetch)
          state_d = DGRANT;
        else if (fetch_ok)
          state_d = IGRANT;
      end
      IGRANT: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = addr_q;
          if (access) begin
            ihit    = 1'b1;
            iload   = bus.ramload;
            state_d = IDLE;
          end else if (expired) begin
            ihit    = 1'b1;
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ram_ren   = ~wen_q;
          ram_wen   = wen_q;
          ram_addr  = addr_q;
          ram_store = store_q;
          if (access) begin
            dhit    = 1'b1;
            dload   = bus.ramload;
            state_d = IDLE;
          end else if (expired) begin
            dhit    = 1'b1;
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on grant entry; held for the whole grant.
  always_comb begin
    addr_d  = addr_q;
    store_d = store_q;
    wen_d   = wen_q;
    if (state_q == IDLE) begin
      if (state_d == DGRANT) begin
        addr_d  = bus.daddr;
        store_d = bus.dstore;
        wen_d   = bus.dWEN;
      end else if (state_d == IGRANT) begin
        addr_d  = bus.iaddr;
        store_d = '0;
        wen_d   = 1'b0;
      end
    end
  end

  always_comb begin
    waitcnt_d = waitcnt_q;
    if (state_q == IDLE)
      waitcnt_d = '0;
    else if (!access)
      waitcnt_d = waitcnt_q + 8'd1;
  end

  always_comb begin
    dstreak_d = dstreak_q;
    if (dhit) begin
      if (!bus.iREN)
        dstreak_d = '0;
      else if (dstreak_q != 3'd7)
        dstreak_d = dstreak_q + 3'd1;
    end else if (ihit) begin
      dstreak_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) waitcnt_q <= '0;
    else       waitcnt_q <= waitcnt_d;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) dstreak_q <= '0;
    else       dstreak_q <= dstreak_d;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST)        bus_err_q <= 1'b0;
    else if (timeout) bus_err_q <= 1'b1;
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.ihit     = ihit;
  assign bus.iload    = iload;
  assign bus.dhit     = dhit;
  assign bus.dload    = dload;
  assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (DSTREAK_MAX=4, TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   n_chk;
  int   n_fail;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    bus.halt     = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    bus.dREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ram: ramREN=%b ramWEN=%b ramaddr=%h, expected 0 0 0", bus.ramREN, bus.ramWEN, bus.ramaddr);
    end
    n_chk++;
    if (bus.ihit !== 1'b0 || bus.dhit !== 1'b0 || bus.bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hits: ihit=%b dhit=%b bus_err=%b, expected 0 0 0", bus.ihit, bus.dhit, bus.bus_err);
    end
    @(negedge CLK);
    nRST = 1'b1;
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic test_single_fetch();
    bus.iREN = 1'b1; bus.iaddr = 32'h100;
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c1: ramREN=%b ihit=%b, expected 0 0", bus.ramREN, bus.ihit);
    end
    @(negedge CLK); #1;
    n_chk++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_hit: ihit=%b iload=%h, expected 1 deadbeef", bus.ihit, bus.iload);
    end
    n_chk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ram: ramREN=%b ramWEN=%b ramaddr=%h, expected 1 0 100", bus.ramREN, bus.ramWEN, bus.ramaddr);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0 || bus.iload !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_c3: ramREN=%b ihit=%b iload=%h, expected 0 0 0", bus.ramREN, bus.ihit, bus.iload);
    end
    @(negedge CLK);
  endtask

  task automatic test_collision();
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    bus.dREN = 1'b1; bus.daddr = 32'h40;
    bus.ramstate = BUSY; bus.ramload = 32'h1111;
    @(negedge CLK); #1;
    n_chk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_dgrant: ramREN=%b ramaddr=%h dhit=%b, expected 1 40 0", bus.ramREN, bus.ramaddr, bus.dhit);
    end
    @(negedge CLK); #1;
    n_chk++;
    if (bus.dhit !== 1'b0 || bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_busy: dhit=%b ihit=%b, expected 0 0", bus.dhit, bus.ihit);
    end
    @(negedge CLK);
    bus.ramstate = ACCESS;
    #1;
    n_chk++;
    if (bus.dhit !== 1'b1 || bus.dload !== 32'h1111 || bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_dhit: dhit=%b dload=%h ihit=%b, expected 1 1111 0", bus.dhit, bus.dload, bus.ihit);
    end
    @(negedge CLK);
    bus.dREN = 1'b0;
    bus.ramload = 32'h2222;
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_idle: ramREN=%b ihit=%b, expected 0 0", bus.ramREN, bus.ihit);
    end
    @(negedge CLK); #1;
    n_chk++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h2222 || bus.ramaddr !== 32'h200) begin
      n_fail++;
      $display("FAIL coll_ihit: ihit=%b iload=%h ramaddr=%h, expected 1 2222 200", bus.ihit, bus.iload, bus.ramaddr);
    end
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic test_starvation();
    int dcount;
    int icount;
    int d_before_i;
    int i_cycle;
    dcount = 0; icount = 0; d_before_i = -1; i_cycle = -1;
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    bus.ramstate = ACCESS; bus.ramload = 32'h77;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge CLK);
      if (icount != 0) bus.iREN = 1'b0;
      #1;
      if (bus.dhit === 1'b1) dcount++;
      if (bus.ihit === 1'b1) begin
        icount++;
        if (i_cycle < 0) begin
          i_cycle = c;
          d_before_i = dcount;
          n_chk++;
          if (bus.ramaddr !== 32'h300) begin
            n_fail++;
            $display("FAIL starve_iaddr: ramaddr=%h, expected 300", bus.ramaddr);
          end
        end
      end
    end
    n_chk++;
    if (d_before_i !== 4) begin
      n_fail++;
      $display("FAIL starve_dcount: dhits before ihit=%0d, expected 4", d_before_i);
    end
    n_chk++;
    if (i_cycle !== 10) begin
      n_fail++;
      $display("FAIL starve_icycle: ihit cycle=%0d, expected 10", i_cycle);
    end
    n_chk++;
    if (icount !== 1 || dcount !== 6) begin
      n_fail++;
      $display("FAIL starve_totals: ihits=%0d dhits=%0d, expected 1 6", icount, dcount);
    end
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    int early_hits;
    int bad_wen;
    early_hits = 0; bad_wen = 0;
    n_chk++;
    if (bus.bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pre: bus_err=%b, expected 0", bus.bus_err);
    end
    bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'hCAFE;
    bus.ramstate = BUSY; bus.ramload = 32'h9999;
    for (int c = 2; c <= 8; c++) begin
      @(negedge CLK); #1;
      if (bus.dhit !== 1'b0) early_hits++;
      if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hCAFE || bus.ramaddr !== 32'h500) bad_wen++;
    end
    n_chk++;
    if (early_hits !== 0 || bad_wen !== 0) begin
      n_fail++;
      $display("FAIL tmo_wait: early dhits=%0d bad ram cycles=%0d, expected 0 0", early_hits, bad_wen);
    end
    @(negedge CLK); #1;
    n_chk++;
    if (bus.dhit !== 1'b1 || bus.dload !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_hit: dhit=%b dload=%h, expected 1 0", bus.dhit, bus.dload);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    n_chk++;
    if (bus.bus_err !== 1'b1 || bus.ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_err: bus_err=%b ramWEN=%b, expected 1 0", bus.bus_err, bus.ramWEN);
    end
    @(negedge CLK);
    @(negedge CLK); #1;
    n_chk++;
    if (bus.bus_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: bus_err=%b, expected 1", bus.bus_err);
    end
  endtask

  task automatic test_halt();
    int grants;
    grants = 0;
    bus.halt = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h600;
    bus.ramstate = ACCESS; bus.ramload = 32'h55;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK); #1;
      if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) grants++;
    end
    n_chk++;
    if (grants !== 0) begin
      n_fail++;
      $display("FAIL halt_block: cycles with fetch activity=%0d, expected 0", grants);
    end
    bus.dREN = 1'b1; bus.daddr = 32'h60;
    @(negedge CLK); #1;
    n_chk++;
    if (bus.dhit !== 1'b1 || bus.dload !== 32'h55 || bus.ramaddr !== 32'h60 || bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_data: dhit=%b dload=%h ramaddr=%h ihit=%b, expected 1 55 60 0", bus.dhit, bus.dload, bus.ramaddr, bus.ihit);
    end
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic test_abort();
    bus.iREN = 1'b1; bus.iaddr = 32'h700; bus.ramstate = BUSY;
    @(negedge CLK); #1;
    n_chk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h700) begin
      n_fail++;
      $display("FAIL abort_grant: ramREN=%b ramaddr=%h, expected 1 700", bus.ramREN, bus.ramaddr);
    end
    @(negedge CLK);
    bus.iREN = 1'b0;
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0 || bus.ramaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_drop: ramREN=%b ihit=%b ramaddr=%h, expected 0 0 0", bus.ramREN, bus.ihit, bus.ramaddr);
    end
    @(negedge CLK);
    bus.ramstate = ACCESS;
    #1;
    n_chk++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: ihit=%b ramREN=%b, expected 0 0", bus.ihit, bus.ramREN);
    end
    idle_inputs();
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_access();
    int late_hits;
    late_hits = 0;
    bus.dREN = 1'b1; bus.daddr = 32'h900; bus.ramstate = BUSY; bus.ramload = 32'hABCD;
    @(negedge CLK); #1;
    n_chk++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h900) begin
      n_fail++;
      $display("FAIL rst_grant: ramREN=%b ramaddr=%h, expected 1 900", bus.ramREN, bus.ramaddr);
    end
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b1 || bus.bus_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_sync: ramREN=%b bus_err=%b, expected 1 1 before edge", bus.ramREN, bus.bus_err);
    end
    @(negedge CLK);
    nRST = 1'b1;
    bus.dREN = 1'b0;
    bus.ramstate = ACCESS;
    #1;
    n_chk++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0 ||
        bus.dhit !== 1'b0 || bus.dload !== 32'h0 || bus.ihit !== 1'b0 || bus.iload !== 32'h0 || bus.bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_outputs: ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h dhit=%b dload=%h ihit=%b iload=%h bus_err=%b, expected all 0",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dhit, bus.dload, bus.ihit, bus.iload, bus.bus_err);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      if (bus.dhit !== 1'b0) late_hits++;
    end
    n_chk++;
    if (late_hits !== 0) begin
      n_fail++;
      $display("FAIL rst_nohit: dhits after reset=%0d, expected 0", late_hits);
    end
    idle_inputs();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_timeout();
    test_halt();
    test_abort();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
